fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer presents valid/data/last; the arbiter grants one producer at a time for a burst of up to MAX_BURST beats. It drives the FIFO's chip select, write enable and data input, and honours the FIFO full flag as backpressure. It sits directly in front of the FIFO's write side.

## Interface
- NUM_REQ, 4, number of requesters (>=2); grant_id width GW = $clog2(NUM_REQ)
- DATA_W, 32, data width; must equal the FIFO data width
- MAX_BURST, 4, maximum beats per grant (>=1); beat_cnt width $clog2(MAX_BURST)+1
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  bit i: requester i has a beat available
- req_data  in  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  bit i: current beat of requester i ends its packet
- req_ready  out  NUM_REQ  bit i: beat of requester i accepted this cycle (combinational)
- fifo_full  in  1  FIFO full flag
- fifo_cs  out  1  FIFO chip select
- fifo_wr_enb  out  1  FIFO write enable
- fifo_data_in  out  DATA_W  FIFO write data
- grant_id  out  GW  index of the currently or last granted requester
- busy  out  1  high in GRANT state

## Operation
- States: IDLE, GRANT. Registers: state, grant_id, rr_ptr (last released requester), beat_cnt.
- IDLE: if any req_valid bit is set, select the first set bit searching circularly from rr_ptr+1 (mod NUM_REQ). Load grant_id, clear beat_cnt, and go to GRANT. Otherwise stay in IDLE.
- GRANT: xfer = req_valid[grant_id] & ~fifo_full.
  - req_ready[grant_id] = xfer. All other req_ready bits are 0.
  - fifo_wr_enb = fifo_cs = xfer.
  - fifo_data_in = req_data slice for grant_id. It is 0 in IDLE.
- On xfer, beat_cnt increments.
- Release (next state IDLE, rr_ptr <= grant_id) on any of:
  - xfer with req_last[grant_id]=1;
  - xfer with beat_cnt == MAX_BURST-1;
  - req_valid[grant_id]=0 in GRANT (requester withdrew; no transfer that cycle).
- fifo_full=1 in GRANT: no transfer. Grant, beat_cnt and state are held. The grant is not released while the requester stays valid.
- Other requesters' valid bits never affect an active grant.
- Every output is a function of registered state plus current inputs. No write ever occurs while fifo_full=1.
- Reset (any time, including mid-burst) takes effect immediately:
  - state=IDLE, grant_id=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority), beat_cnt=0;
  - busy=0, req_ready=0, fifo_wr_enb=0, fifo_cs=0, fifo_data_in=0.
  - A partial burst is abandoned; no beat is written on the reset edge.

## Timing
- Arbitration latency: 1 cycle. Valid seen in IDLE at edge N gives the grant at edge N+1; the first write can occur in cycle N+1.
- Throughput within a grant: 1 beat/cycle while valid=1 and fifo_full=0.
- Re-arbitration bubble: exactly 1 IDLE cycle after every release.
- Steady state with all requesters continuously valid: MAX_BURST beats per (MAX_BURST+1) cycles.
- The FIFO captures data on the same clk edge at which req_ready/fifo_wr_enb are high. There is no extra pipeline stage.
- req_ready depends combinationally on req_valid and fifo_full. Producers must not make req_valid depend on req_ready.

## Test plan
- Reset, then all valid=0 for 5 cycles -> busy=0, fifo_wr_enb=0, grant_id=0 throughout.
- Requesters 0–3 continuously valid, last=0, MAX_BURST=4, FIFO never full:
  - expected grant order is 0,1,2,3,0;
  - each grant writes exactly 4 beats, followed by 1 IDLE cycle;
  - total 20 writes in 25 cycles.
- Requester 2 alone sends 3 beats, last on beat 2 -> grant_id=2, 3 writes, release after the last beat. A subsequent request from requester 2 with others valid is not served first; the search starts at 3.
- fifo_full asserted for 6 cycles mid-burst of requester 1 (after beat 1):
  - fifo_wr_enb=0 and req_ready=0 during the stall;
  - grant_id stays 1;
  - the burst resumes and completes 4 beats total with no data lost or duplicated, checked against a scoreboard.
- Requester 3 drops valid after 2 beats -> release with no write that cycle, rr_ptr=3. The next grant goes to the lowest-index valid requester after 3 circularly (e.g. 0).
- rst asserted asynchronously mid-burst of requester 2 -> outputs reach reset values before the next edge. After release, requester 0 is served first and no beat is written during reset.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
//
// Bundles the producer handshake and the FIFO write-port signals that pass
// through fifo_wr_arbiter.
//
//   req_valid    [NUM_REQ]         producer i has a beat available
//   req_data     [NUM_REQ*DATA_W]  producer i data at [i*DATA_W +: DATA_W]
//   req_last     [NUM_REQ]         producer i's current beat ends its packet
//   req_ready    [NUM_REQ]         producer i's beat is accepted this cycle
//   fifo_full    [1]               FIFO full flag (backpressure)
//   fifo_cs      [1]               FIFO chip select
//   fifo_wr_enb  [1]               FIFO write enable
//   fifo_data_in [DATA_W]          FIFO write data
//   grant_id     [GW]              current / last granted producer
//   busy         [1]               a grant is active
//
// Modports:
//   master - the arbiter's view (drives ready, FIFO controls, status)
//   slave  - the environment's view (producers and FIFO)
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);

  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_cs;
  logic                      fifo_wr_enb;
  logic [DATA_W-1:0]         fifo_data_in;
  logic [GW-1:0]             grant_id;
  logic                      busy;

  modport master (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  fifo_full,
    output req_ready,
    output fifo_cs,
    output fifo_wr_enb,
    output fifo_data_in,
    output grant_id,
    output busy
  );

  modport slave (
    output req_valid,
    output req_data,
    output req_last,
    output fifo_full,
    input  req_ready,
    input  fifo_cs,
    input  fifo_wr_enb,
    input  fifo_data_in,
    input  grant_id,
    input  busy
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter sharing one synchronous FIFO write port among
// NUM_REQ producers. One producer at a time is granted for a burst of up to
// MAX_BURST beats; the grant ends early on a last beat or when the producer
// withdraws valid. FIFO full stalls the burst without releasing it.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - fifo_wr_arbiter_if.master (producer handshake + FIFO write port)
//
// Parameters:
//   NUM_REQ   - number of producers (>= 2)
//   DATA_W    - data width, equal to the FIFO data width
//   MAX_BURST - maximum beats per grant (>= 1)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant_id;
  logic [GW-1:0]   rr_ptr;
  logic [BW-1:0]   beat_cnt;

  logic            pick_found;
  logic [GW-1:0]   pick_id;
  logic            cur_valid;
  logic            cur_last;
  logic [DATA_W-1:0] cur_data;
  logic            xfer;
  logic            burst_end;

  // Index that lies 'off' positions after 'base', wrapping at NUM_REQ.
  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base,
                                             input int off);
    return GW'((int'(base) + off) % NUM_REQ);
  endfunction

  // Circular search starting just after the last released producer. The
  // loop walks from the farthest candidate to the nearest so the nearest
  // valid producer is the one left in pick_id.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[wrap_idx(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick_id    = wrap_idx(rr_ptr, k);
      end
    end
  end

  // Signals of the currently granted producer and the transfer condition.
  // A beat moves only in GRANT, only with the granted producer valid and
  // only while the FIFO has room.
  always_comb begin
    cur_valid = bus.req_valid[grant_id];
    cur_last  = bus.req_last[grant_id];
    cur_data  = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
    xfer      = (state == GRANT) && cur_valid && !bus.fifo_full;
    burst_end = cur_last || (beat_cnt == BW'(MAX_BURST - 1));
  end

  // Ready is one-hot on the granted producer and combinational so the FIFO
  // captures the beat on the same edge the producer sees it accepted.
  always_comb begin
    bus.req_ready = '0;
    if (xfer) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  assign bus.fifo_wr_enb  = xfer;
  assign bus.fifo_cs      = xfer;
  assign bus.fifo_data_in = (state == GRANT) ? cur_data : '0;
  assign bus.grant_id     = grant_id;
  assign bus.busy         = (state == GRANT);

  // Arbiter FSM. IDLE picks the next producer round-robin; GRANT counts
  // beats and releases on last, on burst limit or on withdrawal. A full
  // FIFO freezes everything so the grant survives the stall. rr_ptr resets
  // to the top index so producer 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= GW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!cur_valid) begin
            state  <= IDLE;
            rr_ptr <= grant_id;
          end else if (!bus.fifo_full) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (burst_end) begin
              state  <= IDLE;
              rr_ptr <= grant_id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=32,
// MAX_BURST=4): a vector table, hand-written corner-case sequences and a
// randomized run compared against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ  (NR),
    .DATA_W   (DW),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic        exp_busy;
    logic [1:0]  exp_gid;
    logic        exp_wr;
    logic [3:0]  exp_ready;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [16];

  localparam logic [31:0] D0 = 32'hDA7A_0000;
  localparam logic [31:0] D1 = 32'hDA7A_0001;
  localparam logic [31:0] D2 = 32'hDA7A_0002;
  localparam logic [31:0] D3 = 32'hDA7A_0003;

  // Reference model state, in plain integers.
  int m_busy, m_gid, m_ptr, m_beats;

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic [3:0] l,
                                input logic f);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.fifo_full = f;
  endtask

  task automatic set_fixed_data();
    bus.req_data = {D3, D2, D1, D0};
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset with all inputs quiet; leaves the bench 1 time unit after an edge.
  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(4'b0000, 4'b0000, 1'b0);
    set_fixed_data();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  // Model: outputs from current state and inputs.
  task automatic model_check();
    logic        exp_wr;
    logic [3:0]  exp_ready;
    logic [31:0] exp_data;
    exp_wr    = 1'b0;
    exp_ready = 4'b0000;
    exp_data  = 32'h0;
    if (m_busy != 0) begin
      exp_data = bus.req_data[m_gid*DW +: DW];
      if (bus.req_valid[m_gid] && !bus.fifo_full) begin
        exp_wr           = 1'b1;
        exp_ready[m_gid] = 1'b1;
      end
    end
    check_output("rand_busy",  64'(bus.busy),         64'(m_busy != 0));
    check_output("rand_gid",   64'(bus.grant_id),     64'(m_gid));
    check_output("rand_wr",    64'(bus.fifo_wr_enb),  64'(exp_wr));
    check_output("rand_cs",    64'(bus.fifo_cs),      64'(exp_wr));
    check_output("rand_ready", 64'(bus.req_ready),    64'(exp_ready));
    check_output("rand_data",  64'(bus.fifo_data_in), 64'(exp_data));
  endtask

  // Model: what the clock edge does under the current inputs.
  task automatic model_advance();
    if (m_busy == 0) begin
      for (int k = 1; k <= NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (bus.req_valid[i]) begin
          m_busy  = 1;
          m_gid   = i;
          m_beats = 0;
          break;
        end
      end
    end else if (!bus.req_valid[m_gid]) begin
      m_busy = 0;
      m_ptr  = m_gid;
    end else if (!bus.fifo_full) begin
      m_beats++;
      if (bus.req_last[m_gid] || m_beats == MB) begin
        m_busy = 0;
        m_ptr  = m_gid;
      end
    end
  endtask

  initial begin
    int writes, idles, sent, prev_busy;
    int order[$];
    logic [31:0] got[$];

    vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0};
    vecs[1]  = '{4'b0101, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0};
    vecs[2]  = '{4'b0101, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, D0};
    vecs[3]  = '{4'b0101, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 32'h0};
    vecs[4]  = '{4'b0101, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000, D2};
    vecs[5]  = '{4'b0101, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, D2};
    vecs[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 32'h0};
    vecs[7]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 32'h0};
    vecs[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000, D1};
    vecs[9]  = '{4'b1001, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 32'h0};
    vecs[10] = '{4'b1001, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, D3};
    vecs[11] = '{4'b1001, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, D3};
    vecs[12] = '{4'b1001, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, D3};
    vecs[13] = '{4'b1001, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, D3};
    vecs[14] = '{4'b1001, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000, 32'h0};
    vecs[15] = '{4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, D0};

    // ---- Reset and 5 quiet cycles ----
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("idle_busy", 64'(bus.busy),        64'd0);
      check_output("idle_wr",   64'(bus.fifo_wr_enb), 64'd0);
      check_output("idle_gid",  64'(bus.grant_id),    64'd0);
      next_cycle();
    end

    // ---- Vector table ----
    for (int r = 0; r < 16; r++) begin
      apply_stimulus(vecs[r].valid, vecs[r].last, vecs[r].full);
      @(negedge clk);
      check_output($sformatf("vec%0d_busy", r),  64'(bus.busy),         64'(vecs[r].exp_busy));
      check_output($sformatf("vec%0d_gid", r),   64'(bus.grant_id),     64'(vecs[r].exp_gid));
      check_output($sformatf("vec%0d_wr", r),    64'(bus.fifo_wr_enb),  64'(vecs[r].exp_wr));
      check_output($sformatf("vec%0d_ready", r), 64'(bus.req_ready),    64'(vecs[r].exp_ready));
      check_output($sformatf("vec%0d_data", r),  64'(bus.fifo_data_in), 64'(vecs[r].exp_data));
      next_cycle();
    end

    // ---- All four continuously valid for 25 cycles ----
    do_reset();
    apply_stimulus(4'b1111, 4'b0000, 1'b0);
    writes = 0;
    idles = 0;
    prev_busy = 0;
    order.delete();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.busy && prev_busy == 0) order.push_back(int'(bus.grant_id));
      if (!bus.busy) idles++;
      if (bus.fifo_wr_enb) begin
        writes++;
        check_output("rr_data", 64'(bus.fifo_data_in),
                     64'(32'hDA7A_0000 + 32'(bus.grant_id)));
      end
      prev_busy = int'(bus.busy);
      next_cycle();
    end
    check_output("rr_writes", 64'(writes), 64'd20);
    check_output("rr_idles",  64'(idles),  64'd5);
    check_output("rr_grants", 64'(order.size()), 64'd5);
    if (order.size() == 5) begin
      check_output("rr_order0", 64'(order[0]), 64'd0);
      check_output("rr_order1", 64'(order[1]), 64'd1);
      check_output("rr_order2", 64'(order[2]), 64'd2);
      check_output("rr_order3", 64'(order[3]), 64'd3);
      check_output("rr_order4", 64'(order[4]), 64'd0);
    end

    // ---- Requester 2 alone, 3-beat packet, then pointer moves on ----
    do_reset();
    apply_stimulus(4'b0100, 4'b0000, 1'b0);
    next_cycle();
    writes = 0;
    for (int b = 0; b < 3; b++) begin
      apply_stimulus(4'b0100, (b == 2) ? 4'b0100 : 4'b0000, 1'b0);
      @(negedge clk);
      check_output("r2_gid", 64'(bus.grant_id), 64'd2);
      if (bus.fifo_wr_enb) writes++;
      next_cycle();
    end
    check_output("r2_writes", 64'(writes), 64'd3);
    apply_stimulus(4'b1110, 4'b0000, 1'b0);
    @(negedge clk);
    check_output("r2_release_busy", 64'(bus.busy), 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("r2_next_gid",  64'(bus.grant_id), 64'd3);
    check_output("r2_next_busy", 64'(bus.busy),     64'd1);
    next_cycle();

    // ---- FIFO full stall mid-burst of requester 1 ----
    do_reset();
    sent = 0;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      logic stall;
      stall = (c >= 3 && c <= 8);
      apply_stimulus((sent < 4) ? 4'b0010 : 4'b0000, 4'b0000, stall);
      bus.req_data = '0;
      bus.req_data[1*DW +: DW] = 32'h100 + 32'(sent);
      @(negedge clk);
      if (stall) begin
        check_output("stall_wr",    64'(bus.fifo_wr_enb), 64'd0);
        check_output("stall_ready", 64'(bus.req_ready),   64'd0);
        check_output("stall_gid",   64'(bus.grant_id),    64'd1);
      end
      if (bus.req_ready[1]) begin
        got.push_back(bus.fifo_data_in);
        sent++;
      end
      next_cycle();
    end
    check_output("stall_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      check_output($sformatf("stall_beat%0d", i), 64'(got[i]), 64'(32'h100 + i));
    end
    set_fixed_data();

    // ---- Requester 3 withdraws after 2 beats ----
    do_reset();
    apply_stimulus(4'b1000, 4'b0000, 1'b0);
    next_cycle();
    writes = 0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      if (bus.fifo_wr_enb) writes++;
      next_cycle();
    end
    check_output("drop_writes", 64'(writes), 64'd2);
    apply_stimulus(4'b0011, 4'b0000, 1'b0);
    @(negedge clk);
    check_output("drop_busy",  64'(bus.busy),        64'd1);
    check_output("drop_gid",   64'(bus.grant_id),    64'd3);
    check_output("drop_wr",    64'(bus.fifo_wr_enb), 64'd0);
    check_output("drop_ready", 64'(bus.req_ready),   64'd0);
    next_cycle();
    @(negedge clk);
    check_output("drop_idle", 64'(bus.busy), 64'd0);
    next_cycle();
    @(negedge clk);
    check_output("drop_next_gid",  64'(bus.grant_id), 64'd0);
    check_output("drop_next_busy", 64'(bus.busy),     64'd1);
    next_cycle();

    // ---- Asynchronous reset mid-burst of requester 2 ----
    do_reset();
    apply_stimulus(4'b0100, 4'b0000, 1'b0);
    next_cycle();
    @(negedge clk);
    check_output("arst_pre_gid", 64'(bus.grant_id),    64'd2);
    check_output("arst_pre_wr",  64'(bus.fifo_wr_enb), 64'd1);
    next_cycle();
    #2 rst = 1'b1;
    #1;
    check_output("arst_busy",  64'(bus.busy),         64'd0);
    check_output("arst_wr",    64'(bus.fifo_wr_enb),  64'd0);
    check_output("arst_cs",    64'(bus.fifo_cs),      64'd0);
    check_output("arst_ready", 64'(bus.req_ready),    64'd0);
    check_output("arst_data",  64'(bus.fifo_data_in), 64'd0);
    check_output("arst_gid",   64'(bus.grant_id),     64'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("arst_hold_wr", 64'(bus.fifo_wr_enb), 64'd0);
    rst = 1'b0;
    apply_stimulus(4'b0101, 4'b0000, 1'b0);
    next_cycle();
    @(negedge clk);
    check_output("arst_after_gid",  64'(bus.grant_id), 64'd0);
    check_output("arst_after_busy", 64'(bus.busy),     64'd1);
    next_cycle();

    // ---- Randomized run against the reference model ----
    do_reset();
    m_busy  = 0;
    m_gid   = 0;
    m_ptr   = NR - 1;
    m_beats = 0;
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus(4'($urandom_range(0, 15) | $urandom_range(0, 15)),
                     4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0));
      for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = $urandom;
      @(negedge clk);
      model_check();
      model_advance();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
